// File: rtl/vae_pkg.sv
// Shared constants and the packed output word type for the VAE result path.
package vae_pkg;

    localparam int DATA_W     = 16;
    localparam int LANES      = 4;
    localparam int OUT_W      = DATA_W * LANES;
    localparam int LANE_IDX_W = $clog2(LANES);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [LANES-1:0] keep;
        logic             last;
    } pack_word_t;

    localparam int PACK_W = $bits(pack_word_t);

endpackage

// File: rtl/result_packer_if.sv
// Packed-word stream from the result packer towards the DMA write channel.
interface result_packer_if;
    import vae_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [LANES-1:0] out_keep;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_keep,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_keep,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with full/empty/level and sync active-low reset.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    // Empty FIFO presents zero so stale storage never reaches the bus.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/result_packer.sv
// Packs 16-bit MAC results four to a 64-bit word and streams them to the DMA writer.
// Optional RESULT_PACKER_DROP_CNT_EN adds a saturating drop_cnt output.
module result_packer
    import vae_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        flush,
    input  logic                        clr,
    result_packer_if.master             out_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        ovf
`ifdef RESULT_PACKER_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

    logic [LANES-1:0][DATA_W-1:0] lanes_q, lanes_nxt;
    logic [LANES-1:0]             keep_q, keep_nxt;
    logic [LANE_IDX_W-1:0]        idx_q, idx_nxt;
    logic                         push;
    logic                         pop;
    logic                         drop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic                         fifo_rst_n;
    pack_word_t                   push_word;
    pack_word_t                   head_word;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        lanes_nxt = lanes_q;
        keep_nxt  = keep_q;
        idx_nxt   = idx_q;
        push_word = '0;

        if (in_valid) begin
            lanes_nxt[idx_q] = in_data;
            keep_nxt[idx_q]  = 1'b1;
        end

        // A completing input and a flush in one cycle yield a single last word.
        push           = (in_valid && idx_q == LAST_LANE) || flush;
        push_word.data = lanes_nxt;
        push_word.keep = keep_nxt;
        push_word.last = flush;

        if (push) begin
            lanes_nxt = '0;
            keep_nxt  = '0;
            idx_nxt   = '0;
        end else if (in_valid) begin
            idx_nxt = idx_q + LANE_IDX_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only; the comb block above uses blocking.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            lanes_q <= '0;
            keep_q  <= '0;
            idx_q   <= '0;
            ovf     <= 1'b0;
        end else begin
            lanes_q <= lanes_nxt;
            keep_q  <= keep_nxt;
            idx_q   <= idx_nxt;
            if (drop) ovf <= 1'b1;
        end
    end

    assign pop        = out_if.out_valid && out_if.out_ready;
    assign drop       = push && fifo_full && !pop;
    assign fifo_rst_n = rst_n && !clr;

    sync_fifo #(
        .WIDTH (PACK_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (fifo_rst_n),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_data  = head_word.data;
    assign out_if.out_keep  = head_word.keep;
    assign out_if.out_last  = head_word.last;

`ifdef RESULT_PACKER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            drop_cnt <= '0;
        end else if (drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_result_packer.sv
// Scoreboard bench for result_packer: directed stimulus, expected words queued, monitor pops on handshake.
module tb_result_packer;
    import vae_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              clr;
    logic [2:0]        fifo_level;
    logic              ovf;
`ifdef RESULT_PACKER_DROP_CNT_EN
    logic [15:0]       drop_cnt;
`endif

    result_packer_if out_if ();

    result_packer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .flush      (flush),
        .clr        (clr),
        .out_if     (out_if),
        .fifo_level (fifo_level),
        .ovf        (ovf)
`ifdef RESULT_PACKER_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    pack_word_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic fl);
        in_valid = v;
        in_data  = d;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
    endtask

    task automatic expect_word(input logic [63:0] d, input logic [3:0] k, input logic l);
        pack_word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    task automatic wait_drain();
        int n = 0;
        out_if.out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_if.out_valid) && n < 50) begin
            tick();
            n++;
        end
        check("drain_complete", 64'(exp_q.size()), 64'd0);
        check("drain_level", 64'(fifo_level), 64'd0);
    endtask

    // Monitor: a word is consumed at the next rising edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n && !clr && out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_if.out_data, 64'd0);
                check("unexpected_word_valid", 64'(out_if.out_valid), 64'd0);
            end else begin
                pack_word_t w;
                w = exp_q.pop_front();
                check("out_data", out_if.out_data, w.data);
                check("out_keep", 64'(out_if.out_keep), 64'(w.keep));
                check("out_last", 64'(out_if.out_last), 64'(w.last));
            end
        end
    end

    initial begin
        rst_n            = 1'b0;
        in_valid         = 1'b0;
        in_data          = '0;
        flush            = 1'b0;
        clr              = 1'b0;
        out_if.out_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(out_if.out_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_data", out_if.out_data, 64'd0);
        rst_n = 1'b1;
        tick();

        // Full word, visible right after the fourth input
        expect_word(64'h0004_0003_0002_0001, 4'b1111, 1'b0);
        drive(1, 16'h0001, 0);
        drive(1, 16'h0002, 0);
        drive(1, 16'h0003, 0);
        check("t1_valid_before", 64'(out_if.out_valid), 64'd0);
        drive(1, 16'h0004, 0);
        check("t1_valid_after", 64'(out_if.out_valid), 64'd1);
        check("t1_level", 64'(fifo_level), 64'd1);
        wait_drain();

        // Partial word closed by flush
        expect_word(64'h0000_CCCC_BBBB_AAAA, 4'b0111, 1'b1);
        drive(1, 16'hAAAA, 0);
        drive(1, 16'hBBBB, 0);
        drive(1, 16'hCCCC, 0);
        drive(0, 16'h0000, 1);
        wait_drain();

        // Flush with nothing packed
        expect_word(64'h0, 4'b0000, 1'b1);
        drive(0, 16'h0000, 1);
        wait_drain();

        // Completing input with flush in the same cycle
        out_if.out_ready = 1'b0;
        expect_word(64'h4444_3333_2222_1111, 4'b1111, 1'b1);
        drive(1, 16'h1111, 0);
        drive(1, 16'h2222, 0);
        drive(1, 16'h3333, 0);
        drive(1, 16'h4444, 1);
        check("t4_level", 64'(fifo_level), 64'd1);
        tick();
        check("t4_level_next", 64'(fifo_level), 64'd1);
        wait_drain();

        // Overflow: five words into a depth-4 FIFO with the sink stalled
        out_if.out_ready = 1'b0;
        expect_word(64'h0004_0003_0002_0001, 4'b1111, 1'b0);
        expect_word(64'h0008_0007_0006_0005, 4'b1111, 1'b0);
        expect_word(64'h000C_000B_000A_0009, 4'b1111, 1'b0);
        expect_word(64'h0010_000F_000E_000D, 4'b1111, 1'b0);
        for (int i = 1; i <= 16; i++) drive(1, 16'(i), 0);
        check("t3_level_full", 64'(fifo_level), 64'd4);
        check("t3_ovf_before", 64'(ovf), 64'd0);
        for (int i = 17; i <= 20; i++) drive(1, 16'(i), 0);
        check("t3_level", 64'(fifo_level), 64'd4);
        check("t3_ovf", 64'(ovf), 64'd1);
        check("t3_hold_data", out_if.out_data, 64'h0004_0003_0002_0001);
`ifdef RESULT_PACKER_DROP_CNT_EN
        check("t3_drop_cnt", 64'(drop_cnt), 64'd1);
`endif
        wait_drain();
        check("t3_ovf_sticky", 64'(ovf), 64'd1);

        // Reset with two words queued and two lanes partially filled
        out_if.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) drive(1, 16'h0500 + 16'(i), 0);
        check("t6_level_pre", 64'(fifo_level), 64'd2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_valid", 64'(out_if.out_valid), 64'd0);
        check("t6_rst_level", 64'(fifo_level), 64'd0);
        check("t6_rst_ovf", 64'(ovf), 64'd0);
`ifdef RESULT_PACKER_DROP_CNT_EN
        check("t6_rst_drop_cnt", 64'(drop_cnt), 64'd0);
`endif
        out_if.out_ready = 1'b1;
        expect_word(64'h0044_0033_0022_0011, 4'b1111, 1'b0);
        drive(1, 16'h0011, 0);
        drive(1, 16'h0022, 0);
        drive(1, 16'h0033, 0);
        drive(1, 16'h0044, 0);
        wait_drain();

        // Same again with clr, which must also win over a concurrent input and flush
        out_if.out_ready = 1'b0;
        for (int i = 1; i <= 10; i++) drive(1, 16'h0600 + 16'(i), 0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h9999;
        flush    = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        check("t6_clr_valid", 64'(out_if.out_valid), 64'd0);
        check("t6_clr_level", 64'(fifo_level), 64'd0);
        check("t6_clr_ovf", 64'(ovf), 64'd0);
        out_if.out_ready = 1'b1;
        expect_word(64'h0044_0033_0022_0011, 4'b1111, 1'b0);
        drive(1, 16'h0011, 0);
        drive(1, 16'h0022, 0);
        drive(1, 16'h0033, 0);
        drive(1, 16'h0044, 0);
        wait_drain();

        // Full FIFO: a push with a pop in the same cycle is accepted
        out_if.out_ready = 1'b0;
        expect_word(64'h0103_0102_0101_0100, 4'b1111, 1'b0);
        expect_word(64'h0107_0106_0105_0104, 4'b1111, 1'b0);
        expect_word(64'h010B_010A_0109_0108, 4'b1111, 1'b0);
        expect_word(64'h010F_010E_010D_010C, 4'b1111, 1'b0);
        expect_word(64'h0113_0112_0111_0110, 4'b1111, 1'b0);
        for (int i = 0; i < 19; i++) drive(1, 16'h0100 + 16'(i), 0);
        check("fp_level_full", 64'(fifo_level), 64'd4);
        out_if.out_ready = 1'b1;
        drive(1, 16'h0113, 0);
        check("fp_level", 64'(fifo_level), 64'd4);
        check("fp_ovf", 64'(ovf), 64'd0);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
